snitch_req_arb: RTL and testbench

SNITCH_REQ_ARB -- requirements
Module: snitch_req_arb

---
 rtl/snitch_pkg.sv | 29 ++
 rtl/fifo_v3.sv | 50 +++++
 rtl/snitch_req_arb.sv | 206 ++++++++++++++++++++
 tb/tb_snitch_req_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_pkg.sv
// Shared types for the Snitch request arbiter: AMO opcode encoding, port index and
// round-robin pointer helper.
package snitch_pkg;

  localparam int unsigned MaxNrPorts = 8;

  typedef logic [$clog2(MaxNrPorts)-1:0] port_idx_t;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_t;

  function automatic port_idx_t rr_next(input port_idx_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the port index of every outstanding read.
// Head entry is visible combinationally on data_o.
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  dtype             r_mem [DEPTH];
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW-1:0] r_wr_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AddrW'(DEPTH - 1)) ? '0 : r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AddrW'(DEPTH - 1)) ? '0 : r_rd_ptr + AddrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/snitch_req_arb.sv
// Round-robin arbiter of NrPorts requesters onto one memory port, routing read responses back
// in order. Define SNITCH_REQ_ARB_CUT_EN to insert a spill register on the request path.
module snitch_req_arb
  import snitch_pkg::*;
#(
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned RspFifoDepth = 4,
  parameter type         addr_t       = logic,
  parameter type         data_t       = logic,
  parameter type         strb_t       = logic
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  addr_t              slv_qaddr_i  [NrPorts],
  input  logic [NrPorts-1:0] slv_qwrite_i,
  input  amo_op_t            slv_qamo_i   [NrPorts],
  input  data_t              slv_qdata_i  [NrPorts],
  input  logic [2:0]         slv_qsize_i  [NrPorts],
  input  strb_t              slv_qstrb_i  [NrPorts],
  input  logic [7:0]         slv_qrlen_i  [NrPorts],
  input  logic [NrPorts-1:0] slv_qvalid_i,
  output logic [NrPorts-1:0] slv_qready_o,
  output data_t              slv_pdata_o  [NrPorts],
  output logic [NrPorts-1:0] slv_perror_o,
  output logic [NrPorts-1:0] slv_plast_o,
  output logic [NrPorts-1:0] slv_pvalid_o,
  input  logic [NrPorts-1:0] slv_pready_i,
  output addr_t              mst_qaddr_o,
  output logic               mst_qwrite_o,
  output amo_op_t            mst_qamo_o,
  output data_t              mst_qdata_o,
  output logic [2:0]         mst_qsize_o,
  output strb_t              mst_qstrb_o,
  output logic [7:0]         mst_qrlen_o,
  output logic               mst_qvalid_o,
  input  logic               mst_qready_i,
  input  data_t              mst_pdata_i,
  input  logic               mst_perror_i,
  input  logic               mst_plast_i,
  input  logic               mst_pvalid_i,
  output logic               mst_pready_o
);

  typedef struct packed {
    addr_t      addr;
    logic       write;
    amo_op_t    amo;
    data_t      data;
    logic [2:0] size;
    strb_t      strb;
    logic [7:0] rlen;
  } req_t;

  req_t                  w_slv_req [MaxNrPorts];
  logic [MaxNrPorts-1:0] w_elig_ext;
  logic [MaxNrPorts-1:0] w_pready_ext;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  port_idx_t             w_fifo_head;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;

  port_idx_t             r_ptr;
  port_idx_t             r_lock_idx;
  logic                  r_lock_valid;
  port_idx_t             w_grant;
  logic                  w_arb_valid;
  logic                  w_arb_ready;
  logic                  w_arb_hs;
  req_t                  w_arb_req;
  logic                  w_rr_found;
  logic [31:0]           w_rr_sum;
  logic                  w_mst_valid;
  req_t                  w_mst_req;

  // Reads need a free route slot; writes never produce a response and are always eligible.
  for (genvar gi = 0; gi < MaxNrPorts; gi++) begin : g_req
    if (gi < NrPorts) begin : g_used
      assign w_slv_req[gi] = '{addr: slv_qaddr_i[gi], write: slv_qwrite_i[gi], amo: slv_qamo_i[gi],
                               data: slv_qdata_i[gi], size: slv_qsize_i[gi], strb: slv_qstrb_i[gi],
                               rlen: slv_qrlen_i[gi]};
      assign w_elig_ext[gi] = slv_qvalid_i[gi] & (slv_qwrite_i[gi] | ~w_fifo_full);
    end else begin : g_unused
      assign w_slv_req[gi]  = '0;
      assign w_elig_ext[gi] = 1'b0;
    end
  end

  always_comb begin
    w_grant     = r_ptr;
    w_arb_valid = 1'b0;
    w_rr_found  = 1'b0;
    w_rr_sum    = '0;
    if (r_lock_valid) begin
      w_grant     = r_lock_idx;
      w_arb_valid = w_elig_ext[r_lock_idx];
    end else begin
      for (int unsigned k = 0; k < NrPorts; k++) begin
        w_rr_sum = 32'(r_ptr) + k;
        if (w_rr_sum >= NrPorts) w_rr_sum = w_rr_sum - NrPorts;
        if (!w_rr_found && w_elig_ext[port_idx_t'(w_rr_sum)]) begin
          w_rr_found  = 1'b1;
          w_grant     = port_idx_t'(w_rr_sum);
          w_arb_valid = 1'b1;
        end
      end
    end
    w_arb_valid = w_arb_valid & rst_ni;
  end

  assign w_arb_req = w_slv_req[w_grant];
  assign w_arb_hs  = w_arb_valid & w_arb_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr        <= '0;
      r_lock_idx   <= '0;
      r_lock_valid <= 1'b0;
    end else begin
      r_lock_valid <= w_arb_valid & ~w_arb_ready;
      if (w_arb_valid & ~w_arb_ready) r_lock_idx <= w_grant;
      if (w_arb_hs) r_ptr <= rr_next(w_grant, NrPorts);
    end
  end

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_qready
    assign slv_qready_o[gi] = w_arb_hs & (w_grant == port_idx_t'(gi));
  end

`ifdef SNITCH_REQ_ARB_CUT_EN
  req_t r_a_req;
  req_t r_b_req;
  logic r_a_full;
  logic r_b_full;
  logic w_a_fill;
  logic w_a_drain;
  logic w_b_fill;
  logic w_b_drain;

  // Slot B only fills when A drains into a stalled output, so B always holds the older entry.
  assign w_a_fill    = w_arb_hs;
  assign w_a_drain   = r_a_full & ~r_b_full;
  assign w_b_fill    = w_a_drain & ~mst_qready_i;
  assign w_b_drain   = r_b_full & mst_qready_i;
  assign w_arb_ready = ~r_a_full | ~r_b_full;
  assign w_mst_valid = rst_ni & (r_a_full | r_b_full);
  assign w_mst_req   = r_b_full ? r_b_req : r_a_req;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
    end else begin
      r_a_full <= w_a_fill | (r_a_full & ~w_a_drain);
      r_b_full <= w_b_fill | (r_b_full & ~w_b_drain);
    end
    if (w_a_fill) r_a_req <= w_arb_req;
    if (w_b_fill) r_b_req <= r_a_req;
  end
`else
  assign w_arb_ready = mst_qready_i;
  assign w_mst_valid = w_arb_valid;
  assign w_mst_req   = w_arb_req;
`endif

  assign mst_qvalid_o = w_mst_valid;
  assign mst_qaddr_o  = w_mst_req.addr;
  assign mst_qwrite_o = w_mst_req.write;
  assign mst_qamo_o   = w_mst_req.amo;
  assign mst_qdata_o  = w_mst_req.data;
  assign mst_qsize_o  = w_mst_req.size;
  assign mst_qstrb_o  = w_mst_req.strb;
  assign mst_qrlen_o  = w_mst_req.rlen;

  assign w_fifo_push = w_arb_hs & ~w_arb_req.write;
  assign w_fifo_pop  = mst_pvalid_i & mst_pready_o & mst_plast_i;

  fifo_v3 #(
    .DEPTH (RspFifoDepth),
    .dtype (port_idx_t)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  (w_grant),
    .push_i  (w_fifo_push),
    .data_o  (w_fifo_head),
    .pop_i   (w_fifo_pop)
  );

  assign w_pready_ext = MaxNrPorts'(slv_pready_i);
  assign mst_pready_o = rst_ni & ~w_fifo_empty & w_pready_ext[w_fifo_head];

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_rsp
    assign slv_pvalid_o[gi] = rst_ni & ~w_fifo_empty & mst_pvalid_i & (w_fifo_head == port_idx_t'(gi));
    assign slv_pdata_o[gi]  = mst_pdata_i;
    assign slv_perror_o[gi] = mst_perror_i;
    assign slv_plast_o[gi]  = mst_plast_i;
  end

  a_rsp_needs_route: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_pvalid_i |-> !w_fifo_empty);

endmodule

// File: tb/tb_snitch_req_arb.sv
// Directed bench for snitch_req_arb with two 32-bit ports and a four-entry route FIFO.
module tb_snitch_req_arb;
  import snitch_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] slv_qaddr_i  [2];
  logic [1:0]  slv_qwrite_i;
  amo_op_t     slv_qamo_i   [2];
  logic [31:0] slv_qdata_i  [2];
  logic [2:0]  slv_qsize_i  [2];
  logic [3:0]  slv_qstrb_i  [2];
  logic [7:0]  slv_qrlen_i  [2];
  logic [1:0]  slv_qvalid_i;
  logic [1:0]  slv_qready_o;
  logic [31:0] slv_pdata_o  [2];
  logic [1:0]  slv_perror_o;
  logic [1:0]  slv_plast_o;
  logic [1:0]  slv_pvalid_o;
  logic [1:0]  slv_pready_i;
  logic [31:0] mst_qaddr_o;
  logic        mst_qwrite_o;
  amo_op_t     mst_qamo_o;
  logic [31:0] mst_qdata_o;
  logic [2:0]  mst_qsize_o;
  logic [3:0]  mst_qstrb_o;
  logic [7:0]  mst_qrlen_o;
  logic        mst_qvalid_o;
  logic        mst_qready_i;
  logic [31:0] mst_pdata_i;
  logic        mst_perror_i;
  logic        mst_plast_i;
  logic        mst_pvalid_i;
  logic        mst_pready_o;

  int n_checks = 0;
  int n_errors = 0;

  snitch_req_arb #(
    .NrPorts      (2),
    .RspFifoDepth (4),
    .addr_t       (logic [31:0]),
    .data_t       (logic [31:0]),
    .strb_t       (logic [3:0])
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slv_qaddr_i  (slv_qaddr_i),
    .slv_qwrite_i (slv_qwrite_i),
    .slv_qamo_i   (slv_qamo_i),
    .slv_qdata_i  (slv_qdata_i),
    .slv_qsize_i  (slv_qsize_i),
    .slv_qstrb_i  (slv_qstrb_i),
    .slv_qrlen_i  (slv_qrlen_i),
    .slv_qvalid_i (slv_qvalid_i),
    .slv_qready_o (slv_qready_o),
    .slv_pdata_o  (slv_pdata_o),
    .slv_perror_o (slv_perror_o),
    .slv_plast_o  (slv_plast_o),
    .slv_pvalid_o (slv_pvalid_o),
    .slv_pready_i (slv_pready_i),
    .mst_qaddr_o  (mst_qaddr_o),
    .mst_qwrite_o (mst_qwrite_o),
    .mst_qamo_o   (mst_qamo_o),
    .mst_qdata_o  (mst_qdata_o),
    .mst_qsize_o  (mst_qsize_o),
    .mst_qstrb_o  (mst_qstrb_o),
    .mst_qrlen_o  (mst_qrlen_o),
    .mst_qvalid_o (mst_qvalid_o),
    .mst_qready_i (mst_qready_i),
    .mst_pdata_i  (mst_pdata_i),
    .mst_perror_i (mst_perror_i),
    .mst_plast_i  (mst_plast_i),
    .mst_pvalid_i (mst_pvalid_i),
    .mst_pready_o (mst_pready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic wr, input logic [31:0] addr,
                          input logic [7:0] rlen);
    slv_qvalid_i[p] = v;
    slv_qwrite_i[p] = wr;
    slv_qaddr_i[p]  = addr;
    slv_qdata_i[p]  = addr ^ 32'h5A5A_0000;
    slv_qrlen_i[p]  = rlen;
  endtask

  initial begin
    rst_ni       = 1'b0;
    mst_qready_i = 1'b0;
    mst_pdata_i  = '0;
    mst_perror_i = 1'b0;
    mst_plast_i  = 1'b0;
    mst_pvalid_i = 1'b0;
    slv_pready_i = 2'b00;
    for (int p = 0; p < 2; p++) begin
      slv_qamo_i[p]  = AMONone;
      slv_qsize_i[p] = 3'd2;
      slv_qstrb_i[p] = 4'hF;
      set_port(p, 1'b0, 1'b0, 32'h0, 8'h0);
    end

    // Reset with traffic on every input: outputs must stay quiet.
    set_port(0, 1'b1, 1'b0, 32'h10, 8'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 8'h0);
    mst_qready_i = 1'b1;
    mst_pvalid_i = 1'b1;
    slv_pready_i = 2'b11;
    tick();
    tick();
    check("rst_qvalid", mst_qvalid_o, 0);
    check("rst_qready", slv_qready_o, 0);
    check("rst_pvalid", slv_pvalid_o, 0);
    check("rst_pready", mst_pready_o, 0);
    slv_qvalid_i = 2'b00;
    mst_pvalid_i = 1'b0;
    rst_ni       = 1'b1;
    settle();
    check("rst_ptr", dut.r_ptr, 0);
    check("rst_count", dut.i_route_fifo.r_count, 0);

`ifdef SNITCH_REQ_ARB_CUT_EN
    // Spill register: grants each cycle, outputs one cycle later.
    set_port(0, 1'b1, 1'b0, 32'h10, 8'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 8'h0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("cut_grant", slv_qready_o, (k % 2 == 1) ? 2 : 1);
      if (k == 0) check("cut_lat_valid", mst_qvalid_o, 0);
      else check("cut_addr", mst_qaddr_o, (k % 2 == 1) ? 32'h10 : 32'h20);
      tick();
    end
    slv_qvalid_i = 2'b00;
    settle();
    check("cut_tail_valid", mst_qvalid_o, 1);
    check("cut_tail_addr", mst_qaddr_o, 32'h20);
    check("cut_count", dut.i_route_fifo.r_count, 4);
    tick();
    check("cut_idle", mst_qvalid_o, 0);
`else
    // Two reading ports, always ready: grants alternate 0,1,0,1.
    set_port(0, 1'b1, 1'b0, 32'h10, 8'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 8'h0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_addr", mst_qaddr_o, (k % 2 == 1) ? 32'h20 : 32'h10);
      check("rr_grant", slv_qready_o, (k % 2 == 1) ? 2 : 1);
      tick();
    end
    slv_qvalid_i = 2'b00;
    mst_qready_i = 1'b0;
    settle();
    check("rr_count", dut.i_route_fifo.r_count, 4);
    check("rr_idle", mst_qvalid_o, 0);
    mst_pvalid_i = 1'b1;
    mst_plast_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mst_pdata_i = 32'hA0 + 32'(k);
      settle();
      check("rr_route", slv_pvalid_o, (k % 2 == 1) ? 2 : 1);
      check("rr_pdata", slv_pdata_o[k % 2], 32'hA0 + 32'(k));
      tick();
    end
    mst_pvalid_i = 1'b0;
    settle();
    check("rr_drained", dut.i_route_fifo.r_count, 0);

    // Stalled write from port 1 must not be displaced by port 0.
    set_port(1, 1'b1, 1'b1, 32'h100, 8'h0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lock_addr", mst_qaddr_o, 32'h100);
      check("lock_valid", mst_qvalid_o, 1);
      check("lock_noready", slv_qready_o, 0);
      tick();
    end
    set_port(0, 1'b1, 1'b0, 32'h40, 8'h3);
    for (int k = 0; k < 2; k++) begin
      settle();
      check("lock_hold_addr", mst_qaddr_o, 32'h100);
      check("lock_hold_write", mst_qwrite_o, 1);
      tick();
    end
    mst_qready_i = 1'b1;
    settle();
    check("lock_accept", slv_qready_o, 2);
    check("lock_accept_addr", mst_qaddr_o, 32'h100);
    tick();
    slv_qvalid_i[1] = 1'b0;
    settle();
    check("next_addr", mst_qaddr_o, 32'h40);
    check("next_rlen", mst_qrlen_o, 3);
    check("next_grant", slv_qready_o, 1);
    tick();
    slv_qvalid_i = 2'b00;
    mst_qready_i = 1'b0;
    settle();
    check("write_no_push", dut.i_route_fifo.r_count, 1);

    // Four-beat burst to port 0 with a two-cycle upstream stall on beat 1.
    mst_pvalid_i = 1'b1;
    mst_plast_i  = 1'b0;
    mst_pdata_i  = 32'hB0;
    settle();
    check("burst_route0", slv_pvalid_o, 1);
    check("burst_pready0", mst_pready_o, 1);
    tick();
    check("burst_nopop0", dut.i_route_fifo.r_count, 1);
    mst_pdata_i  = 32'hB1;
    slv_pready_i = 2'b10;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("stall_pready", mst_pready_o, 0);
      check("stall_pvalid", slv_pvalid_o, 1);
      check("stall_nopop", dut.i_route_fifo.r_count, 1);
      tick();
    end
    slv_pready_i = 2'b11;
    settle();
    check("burst_pready1", mst_pready_o, 1);
    check("burst_pdata1", slv_pdata_o[0], 32'hB1);
    tick();
    mst_pdata_i = 32'hB2;
    tick();
    check("burst_nopop2", dut.i_route_fifo.r_count, 1);
    mst_pdata_i = 32'hB3;
    mst_plast_i = 1'b1;
    settle();
    check("burst_last", slv_plast_o & slv_pvalid_o, 1);
    tick();
    mst_pvalid_i = 1'b0;
    mst_plast_i  = 1'b0;
    settle();
    check("burst_pop", dut.i_route_fifo.r_count, 0);

    // Fill the route FIFO, leaving the pointer at 0.
    mst_qready_i = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h10, 8'h0);
    settle();
    check("fill_first", slv_qready_o, 1);
    tick();
    set_port(1, 1'b1, 1'b0, 32'h20, 8'h0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("fill_addr", mst_qaddr_o, (k % 2 == 0) ? 32'h20 : 32'h10);
      tick();
    end
    slv_qvalid_i = 2'b00;
    settle();
    check("full_count", dut.i_route_fifo.r_count, 4);
    check("full_ptr", dut.r_ptr, 0);

    // Full: write still passes, read waits for a last beat and not in the same cycle.
    set_port(0, 1'b1, 1'b0, 32'h50, 8'h0);
    set_port(1, 1'b1, 1'b1, 32'h60, 8'h0);
    settle();
    check("full_write_addr", mst_qaddr_o, 32'h60);
    check("full_write_grant", slv_qready_o, 2);
    tick();
    slv_qvalid_i[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("full_read_block", mst_qvalid_o, 0);
      check("full_read_noready", slv_qready_o, 0);
      tick();
    end
    mst_pvalid_i = 1'b1;
    mst_plast_i  = 1'b1;
    settle();
    check("full_pop_block", mst_qvalid_o, 0);
    check("full_pop_route", slv_pvalid_o, 1);
    tick();
    mst_pvalid_i = 1'b0;
    settle();
    check("after_pop_count", dut.i_route_fifo.r_count, 3);
    check("after_pop_addr", mst_qaddr_o, 32'h50);
    check("after_pop_grant", slv_qready_o, 1);
    tick();
    slv_qvalid_i = 2'b00;
    settle();
    check("refill_count", dut.i_route_fifo.r_count, 4);

    // Drain one, then push and pop in the same cycle.
    mst_pvalid_i = 1'b1;
    settle();
    check("drain_head1", slv_pvalid_o, 2);
    tick();
    set_port(1, 1'b1, 1'b0, 32'h70, 8'h0);
    settle();
    check("pushpop_route", slv_pvalid_o, 1);
    check("pushpop_grant", slv_qready_o, 2);
    tick();
    slv_qvalid_i = 2'b00;
    mst_pvalid_i = 1'b0;
    settle();
    check("pushpop_count", dut.i_route_fifo.r_count, 3);
    mst_pvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("drain_order", slv_pvalid_o, (k % 2 == 0) ? 2 : 1);
      tick();
    end
    mst_pvalid_i = 1'b0;
    mst_plast_i  = 1'b0;
    settle();
    check("drain_empty", dut.i_route_fifo.r_count, 0);

    // Reset with two reads outstanding and a response mid-flight.
    set_port(0, 1'b1, 1'b0, 32'h90, 8'h0);
    for (int k = 0; k < 2; k++) begin
      settle();
      check("pre_rst_grant", slv_qready_o, 1);
      tick();
    end
    settle();
    check("pre_rst_ptr", dut.r_ptr, 1);
    check("pre_rst_count", dut.i_route_fifo.r_count, 2);
    rst_ni       = 1'b0;
    mst_pvalid_i = 1'b1;
    settle();
    check("mid_rst_qvalid", mst_qvalid_o, 0);
    check("mid_rst_qready", slv_qready_o, 0);
    check("mid_rst_pvalid", slv_pvalid_o, 0);
    check("mid_rst_pready", mst_pready_o, 0);
    tick();
    slv_qvalid_i = 2'b00;
    mst_pvalid_i = 1'b0;
    rst_ni       = 1'b1;
    settle();
    check("post_rst_count", dut.i_route_fifo.r_count, 0);
    check("post_rst_ptr", dut.r_ptr, 0);
    check("post_rst_pready", mst_pready_o, 0);
    check("post_rst_qvalid", mst_qvalid_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
